// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared definitions for the button interrupt controller:
//               register window offsets, channel limit and a constant
//               log2 helper used to size the debounce counters.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    // Upper bound on channel count; also the width of each STATUS field.
    localparam int MAX_IRQ = 8;

    // Byte offsets inside the 16-byte register window.
    localparam logic [3:0] REG_PENDING = 4'h0;
    localparam logic [3:0] REG_MASK    = 4'h4;
    localparam logic [3:0] REG_COUNT   = 4'h8;
    localparam logic [3:0] REG_STATUS  = 4'hC;

    // Bits needed to hold the values 0 .. value-1 (value >= 2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_debounce.sv
`default_nettype none
// ============================================================================
// Module      : irq_debounce
// Description : One input channel: two-flop synchronizer, debounce counter,
//               debounced (stable) level and a rising-edge pulse.
//               A new level is accepted once the synchronized input has
//               differed from the stable level for DEBOUNCE_CYCLES cycles.
// Ports       : clk      - system clock
//               resetn   - asynchronous active-low reset
//               i_btn    - raw asynchronous input level
//               o_synced - synchronized input level
//               o_stable - debounced level
//               o_rise   - combinational pulse, high in the cycle before
//                          the edge at which stable goes 0->1
// Revision    : 1.0 - initial release
// ============================================================================
module irq_debounce
    import irq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_btn,
    output logic o_synced,
    output logic o_stable,
    output logic o_rise
);

    localparam int                  c_cnt_w   = clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_differs;
    logic               w_accept;

    assign w_differs = (r_sync != r_stable);
    // Counter has seen DEBOUNCE_CYCLES-1 differing edges and the level still
    // differs: this edge is the DEBOUNCE_CYCLES-th, so take the new level.
    assign w_accept  = w_differs && (r_cnt == c_cnt_max);

    assign o_synced  = r_sync;
    assign o_stable  = r_stable;
    assign o_rise    = w_accept && r_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_button_ctrl
// Description : Debounced button/switch interrupt source with a 16-byte
//               register window on the core memory bus.
//               Each accepted rising edge latches a pending bit and bumps a
//               wrapping edge counter; irq_out = registered pending & mask.
// Ports       : clk, resetn          - clock, async active-low reset
//               btn_in[NUM_IRQ]      - raw button levels
//               mem_valid/addr/wdata/wstrb - core bus request (wstrb=0: read)
//               sel                  - combinational window hit
//               mem_ready            - one-cycle acknowledge
//               mem_rdata            - read data, zero outside ready cycle
//               irq_out[NUM_IRQ]     - level interrupts
//               irq_count[8]         - accepted rising edges, wraps
// Registers   : 0x0 PENDING (W1C) 0x4 MASK  0x8 COUNT (write clears)
//               0xC STATUS {stable[15:8], synced[7:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module irq_button_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ         = 4,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0010
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] btn_in,
    input  logic               mem_valid,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_wstrb,
    output logic               sel,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata,
    output logic [NUM_IRQ-1:0] irq_out,
    output logic [7:0]         irq_count
);

    logic [NUM_IRQ-1:0] w_synced;
    logic [NUM_IRQ-1:0] w_stable;
    logic [NUM_IRQ-1:0] w_rise;
    logic [7:0]         w_rise_cnt;

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_irq;
    logic [7:0]         r_count;
    logic               r_ready;
    logic [31:0]        r_rdata;

    logic               w_access;
    logic               w_wr;
    logic [3:0]         w_reg_off;
    logic [NUM_IRQ-1:0] w_pend_clr;
    logic               w_mask_we;
    logic               w_count_clr;
    logic [31:0]        w_rd_data;
    logic [MAX_IRQ-1:0] w_stable_pad;
    logic [MAX_IRQ-1:0] w_synced_pad;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Per-channel synchronizer + debounce
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
            irq_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .resetn   (resetn),
                .i_btn    (btn_in[gi]),
                .o_synced (w_synced[gi]),
                .o_stable (w_stable[gi]),
                .o_rise   (w_rise[gi])
            );
        end
    endgenerate

    // Several channels may rise together; all of them are counted.
    always_comb begin
        w_rise_cnt = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_rise_cnt = w_rise_cnt + 8'(w_rise[i]);
        end
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign sel       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    // A new transfer starts only while not acknowledging, which forces a
    // gap cycle between consecutive acknowledges.
    assign w_access  = sel && !r_ready;
    assign w_wr      = w_access && (mem_wstrb != 4'b0000);
    assign w_reg_off = {mem_addr[3:2], 2'b00};

    assign w_pend_clr  = (w_wr && (w_reg_off == REG_PENDING) && mem_wstrb[0])
                         ? mem_wdata[NUM_IRQ-1:0] : '0;
    assign w_mask_we   = w_wr && (w_reg_off == REG_MASK) && mem_wstrb[0];
    assign w_count_clr = w_wr && (w_reg_off == REG_COUNT);

    always_comb begin
        w_stable_pad                = '0;
        w_synced_pad                = '0;
        w_stable_pad[NUM_IRQ-1:0]   = w_stable;
        w_synced_pad[NUM_IRQ-1:0]   = w_synced;
    end

    always_comb begin
        w_rd_data = '0;
        case (w_reg_off)
            REG_PENDING: w_rd_data[NUM_IRQ-1:0] = r_pending;
            REG_MASK:    w_rd_data[NUM_IRQ-1:0] = r_mask;
            REG_COUNT:   w_rd_data[7:0]         = r_count;
            REG_STATUS:  w_rd_data[15:0]        = {w_stable_pad, w_synced_pad};
            default:     w_rd_data              = '0;
        endcase
    end

    // Address low bits and upper write-data bits have no function here.
    assign w_unused = ^{mem_addr[1:0], mem_wdata[31:NUM_IRQ]};

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= '0;
            r_mask    <= '1;
            r_irq     <= '0;
            r_count   <= '0;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            // Rise is OR-ed after the clear so a coincident set wins.
            r_pending <= (r_pending & ~w_pend_clr) | w_rise;
            if (w_mask_we) begin
                r_mask <= mem_wdata[NUM_IRQ-1:0];
            end
            // A clear coinciding with rises leaves just this cycle's rises.
            r_count   <= w_count_clr ? w_rise_cnt : (r_count + w_rise_cnt);
            r_irq     <= r_pending & r_mask;
            r_ready   <= w_access;
            r_rdata   <= w_access ? w_rd_data : '0;
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign irq_out   = r_irq;
    assign irq_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_irq_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_button_ctrl
// Description : Self-checking bench for irq_button_ctrl (4 channels,
//               16-cycle debounce, window at 0x1000_0010).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_button_ctrl;

    logic        clk;
    logic        resetn;
    logic [3:0]  btn_in;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  irq_out;
    logic [7:0]  irq_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_ready;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_irq;
    } vec_t;

    vec_t vecs [20];

    irq_button_ctrl #(
        .NUM_IRQ         (4),
        .DEBOUNCE_CYCLES (16),
        .BASE_ADDR       (32'h1000_0010)
    ) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .btn_in    (btn_in),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .sel       (sel),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .irq_out   (irq_out),
        .irq_count (irq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge; consumes two negedges.
    task automatic bus(input string nm, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic exp_rdy, input logic [31:0] exp_rd);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        #1;
        check({nm, ".sel"}, 32'(sel), 32'(exp_rdy));
        @(negedge clk);
        check({nm, ".ready"}, 32'(mem_ready), 32'(exp_rdy));
        check({nm, ".rdata"}, mem_rdata, exp_rd);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        check({nm, ".ready_low"}, 32'(mem_ready), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h1000_0010, 32'h0,    4'h0, 1'b1, 32'h4,   4'h4};
        vecs[1]  = '{32'h1000_0017, 32'h0,    4'h0, 1'b1, 32'hF,   4'h4};
        vecs[2]  = '{32'h1000_0018, 32'h0,    4'h0, 1'b1, 32'h2,   4'h4};
        vecs[3]  = '{32'h1000_001C, 32'h0,    4'h0, 1'b1, 32'h404, 4'h4};
        vecs[4]  = '{32'h1000_001C, 32'hFFFF, 4'hF, 1'b1, 32'h404, 4'h4};
        vecs[5]  = '{32'h1000_001C, 32'h0,    4'h0, 1'b1, 32'h404, 4'h4};
        vecs[6]  = '{32'h1000_0014, 32'hB,    4'h1, 1'b1, 32'hF,   4'h0};
        vecs[7]  = '{32'h1000_0014, 32'h0,    4'h0, 1'b1, 32'hB,   4'h0};
        vecs[8]  = '{32'h1000_0014, 32'hF,    4'h2, 1'b1, 32'hB,   4'h0};
        vecs[9]  = '{32'h1000_0014, 32'h0,    4'h0, 1'b1, 32'hB,   4'h0};
        vecs[10] = '{32'h1000_0014, 32'hF,    4'h1, 1'b1, 32'hB,   4'h4};
        vecs[11] = '{32'h1000_0010, 32'h4,    4'h2, 1'b1, 32'h4,   4'h4};
        vecs[12] = '{32'h1000_0010, 32'hB,    4'h1, 1'b1, 32'h4,   4'h4};
        vecs[13] = '{32'h1000_0010, 32'h0,    4'h0, 1'b1, 32'h4,   4'h4};
        vecs[14] = '{32'h1000_0010, 32'h4,    4'h1, 1'b1, 32'h4,   4'h0};
        vecs[15] = '{32'h1000_0010, 32'h0,    4'h0, 1'b1, 32'h0,   4'h0};
        vecs[16] = '{32'h1000_0018, 32'h0,    4'h8, 1'b1, 32'h2,   4'h0};
        vecs[17] = '{32'h1000_0018, 32'h0,    4'h0, 1'b1, 32'h0,   4'h0};
        vecs[18] = '{32'h1000_0020, 32'h0,    4'h0, 1'b0, 32'h0,   4'h0};
        vecs[19] = '{32'h0000_0010, 32'h0,    4'h0, 1'b0, 32'h0,   4'h0};

        resetn    = 1'b0;
        btn_in    = 4'hF;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;

        // --- reset state with all buttons held ---
        step(2);
        check("rst.irq_out",   32'(irq_out),   32'd0);
        check("rst.ready",     32'(mem_ready), 32'd0);
        check("rst.rdata",     mem_rdata,      32'd0);
        check("rst.count",     32'(irq_count), 32'd0);
        resetn = 1'b1;
        bus("rst.mask_rd", 32'h1000_0014, 32'h0, 4'h0, 1'b1, 32'hF);
        step(15);
        check("rst.count_17", 32'(irq_count), 32'd0);
        step(1);
        check("rst.count_18", 32'(irq_count), 32'd4);
        check("rst.irq_18",   32'(irq_out),   32'd0);
        step(1);
        check("rst.irq_19",   32'(irq_out),   32'hF);
        btn_in = 4'h0;
        step(20);
        bus("init.w1c",   32'h1000_0010, 32'hF, 4'h1, 1'b1, 32'hF);
        bus("init.cntclr", 32'h1000_0018, 32'h0, 4'hF, 1'b1, 32'h4);
        check("init.count", 32'(irq_count), 32'd0);
        check("init.irq",   32'(irq_out),   32'd0);

        // --- glitch rejection then a clean 30-cycle press ---
        btn_in = 4'h1;
        step(10);
        btn_in = 4'h0;
        step(30);
        check("glitch.count", 32'(irq_count), 32'd0);
        check("glitch.irq",   32'(irq_out),   32'd0);
        btn_in = 4'h1;
        step(17);
        check("press.count_17", 32'(irq_count), 32'd0);
        step(1);
        check("press.count_18", 32'(irq_count), 32'd1);
        check("press.irq_18",   32'(irq_out),   32'd0);
        step(1);
        check("press.irq_19",   32'(irq_out),   32'd1);
        step(11);
        btn_in = 4'h0;
        step(20);

        // --- read with valid held: one ready, then a gap ---
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0010;
        mem_wstrb = 4'h0;
        @(negedge clk);
        check("hold.ready1", 32'(mem_ready), 32'd1);
        check("hold.rdata1", mem_rdata,      32'h1);
        @(negedge clk);
        check("hold.ready2", 32'(mem_ready), 32'd0);
        check("hold.rdata2", mem_rdata,      32'h0);
        mem_valid = 1'b0;
        @(negedge clk);
        check("hold.ready3", 32'(mem_ready), 32'd0);
        bus("w1c0", 32'h1000_0010, 32'h1, 4'h1, 1'b1, 32'h1);
        check("w1c0.irq", 32'(irq_out), 32'd0);

        // --- masked channel still latches and counts ---
        bus("mask0", 32'h1000_0014, 32'h0, 4'h1, 1'b1, 32'hF);
        btn_in = 4'h4;
        step(25);
        check("masked.count", 32'(irq_count), 32'd2);
        check("masked.irq",   32'(irq_out),   32'd0);
        bus("masked.pend", 32'h1000_0010, 32'h0, 4'h0, 1'b1, 32'h4);
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0014;
        mem_wdata = 32'hF;
        mem_wstrb = 4'h1;
        @(negedge clk);
        check("unmask.irq_n1", 32'(irq_out), 32'd0);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        check("unmask.irq_n2", 32'(irq_out), 32'h4);

        // --- register table ---
        for (int i = 0; i < 20; i++) begin
            bus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                vecs[i].exp_ready, vecs[i].exp_rdata);
            check($sformatf("vec%0d.irq", i), 32'(irq_out), 32'(vecs[i].exp_irq));
        end
        btn_in = 4'h0;
        step(20);

        // --- W1C coinciding with a rise on the same bit: set wins ---
        btn_in = 4'h2;
        step(17);
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0010;
        mem_wdata = 32'h2;
        mem_wstrb = 4'h1;
        @(negedge clk);
        check("coll_w1c.ready", 32'(mem_ready), 32'd1);
        check("coll_w1c.count", 32'(irq_count), 32'd1);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        bus("coll_w1c.pend", 32'h1000_0010, 32'h0, 4'h0, 1'b1, 32'h2);
        btn_in = 4'h0;
        step(20);

        // --- COUNT clear coinciding with one rise ---
        btn_in = 4'h8;
        step(17);
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0018;
        mem_wdata = 32'h0;
        mem_wstrb = 4'hF;
        @(negedge clk);
        check("coll_cnt.count", 32'(irq_count), 32'd1);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        bus("coll_cnt.rd", 32'h1000_0018, 32'h0, 4'h0, 1'b1, 32'h1);
        btn_in = 4'h0;
        step(20);
        bus("pre_wrap.w1c", 32'h1000_0010, 32'hF, 4'h1, 1'b1, 32'hA);
        bus("pre_wrap.clr", 32'h1000_0018, 32'h0, 4'h1, 1'b1, 32'h1);

        // --- 256 accepted edges wrap the counter ---
        for (int k = 0; k < 64; k++) begin
            btn_in = 4'hF;
            step(20);
            btn_in = 4'h0;
            step(20);
            if (k == 62) begin
                check("wrap.count_252", 32'(irq_count), 32'd252);
            end
        end
        check("wrap.count_0", 32'(irq_count), 32'd0);
        check("wrap.irq",     32'(irq_out),   32'hF);

        // --- async reset during an acknowledge ---
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0018;
        mem_wstrb = 4'h0;
        @(negedge clk);
        check("arst.ready_pre", 32'(mem_ready), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst.ready", 32'(mem_ready), 32'd0);
        check("arst.irq",   32'(irq_out),   32'd0);
        check("arst.rdata", mem_rdata,      32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
